// File: rtl/offload_mailbox.sv
// Offload mailbox: AVMM slave window for an embedded CPU. It has a host-to-CPU
// FIFO, a CPU-to-host first-word-fall-through FIFO, sticky error flags, a
// done doorbell and a scratch register. Each access gets exactly one wait state.
module offload_mailbox #(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 5
) (
   input  logic        clk,
   input  logic        rst,
   // CPU-side AVMM slave
   output logic        avs_waitrequest,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [23:0] avs_address,
   input  logic [31:0] avs_writedata,
   input  logic [3:0]  avs_byteenable,
   output logic        avs_readdatavalid,
   output logic [31:0] avs_readdata,
   // host-to-CPU stream
   input  logic        h2c_valid,
   output logic        h2c_ready,
   input  logic [31:0] h2c_data,
   // CPU-to-host stream
   output logic        c2h_valid,
   input  logic        c2h_ready,
   output logic [31:0] c2h_data,
   // job-complete doorbell
   output logic        done_pulse
);

   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [2:0] SEL_H2C     = 3'd0;
   localparam logic [2:0] SEL_C2H     = 3'd1;
   localparam logic [2:0] SEL_STATUS  = 3'd2;
   localparam logic [2:0] SEL_CTRL    = 3'd3;
   localparam logic [2:0] SEL_SCRATCH = 3'd4;

   // Register word select; the remaining address bits alias onto the same map.
   logic [2:0] reg_sel;
   logic       unused_addr;
   assign reg_sel     = avs_address[4:2];
   assign unused_addr = ^{avs_address[23:5], avs_address[1:0]};

   // Access handshake. acc_phase marks the second cycle of an access. That
   // cycle is the accept cycle. A reset on that cycle cancels the access.
   logic acc_phase;
   logic strobe;
   logic accept;
   logic wr_acc;
   logic rd_acc;

   assign strobe          = avs_read | avs_write;
   assign avs_waitrequest = strobe & ~acc_phase;
   assign accept          = strobe & acc_phase & ~rst;
   assign wr_acc          = accept & avs_write;
   assign rd_acc          = accept & avs_read & ~avs_write;

   // FIFO state
   logic [31:0]      h2c_mem [FIFO_DEPTH];
   logic [AW-1:0]    h2c_wptr;
   logic [AW-1:0]    h2c_rptr;
   logic [CNT_W-1:0] h2c_count;
   logic             h2c_full;
   logic             h2c_empty;

   logic [31:0]      c2h_mem [FIFO_DEPTH];
   logic [AW-1:0]    c2h_wptr;
   logic [AW-1:0]    c2h_rptr;
   logic [CNT_W-1:0] c2h_count;
   logic             c2h_full;
   logic             c2h_empty;

   assign h2c_full  = (h2c_count == CNT_W'(FIFO_DEPTH));
   assign h2c_empty = (h2c_count == '0);
   assign c2h_full  = (c2h_count == CNT_W'(FIFO_DEPTH));
   assign c2h_empty = (c2h_count == '0);

   assign h2c_ready = ~h2c_full;
   assign c2h_valid = ~c2h_empty;
   assign c2h_data  = c2h_mem[c2h_rptr];

   // Full and empty use the pre-update count. A push into a full FIFO and a
   // pop from an empty FIFO both fail, even when the other side moves in the
   // same cycle.
   logic h2c_push;
   logic h2c_pop_req;
   logic h2c_pop;
   logic c2h_push_req;
   logic c2h_push;
   logic c2h_pop;
   logic ctrl_wr;
   logic scratch_wr;

   assign h2c_push     = h2c_valid & ~h2c_full;
   assign h2c_pop_req  = rd_acc & (reg_sel == SEL_H2C);
   assign h2c_pop      = h2c_pop_req & ~h2c_empty;
   assign c2h_push_req = wr_acc & (reg_sel == SEL_C2H) & (avs_byteenable == 4'hF);
   assign c2h_push     = c2h_push_req & ~c2h_full;
   assign c2h_pop      = c2h_valid & c2h_ready;
   assign ctrl_wr      = wr_acc & (reg_sel == SEL_CTRL) & avs_byteenable[0];
   assign scratch_wr   = wr_acc & (reg_sel == SEL_SCRATCH);

   logic        h2c_underflow;
   logic        c2h_overflow;
   logic [31:0] scratch;

   // Pack the status word from the live state at the accept cycle.
   function automatic logic [31:0] pack_status(
      input logic             h_empty,
      input logic             c_full,
      input logic [CNT_W-1:0] h_cnt,
      input logic [CNT_W-1:0] c_cnt,
      input logic             h_unf,
      input logic             c_ovf
   );
      logic [31:0] s;
      s             = '0;
      s[0]          = h_empty;
      s[1]          = c_full;
      s[8 +: CNT_W] = h_cnt;
      s[16 +: CNT_W]= c_cnt;
      s[24]         = h_unf;
      s[25]         = c_ovf;
      return s;
   endfunction

   // Read-data mux for the accepted register.
   logic [31:0] rd_mux;
   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         SEL_H2C:     rd_mux = h2c_empty ? 32'h0 : h2c_mem[h2c_rptr];
         SEL_STATUS:  rd_mux = pack_status(h2c_empty, c2h_full, h2c_count,
                                           c2h_count, h2c_underflow, c2h_overflow);
         SEL_SCRATCH: rd_mux = scratch;
         default:     rd_mux = '0;
      endcase
   end

   // Track the wait-state and accept phases of each access.
   always_ff @(posedge clk) begin
      if (rst) acc_phase <= 1'b0;
      else     acc_phase <= strobe & ~acc_phase;
   end

   // FIFO storage; contents are not reset, only pointers and counts are.
   always_ff @(posedge clk) begin
      if (h2c_push) h2c_mem[h2c_wptr] <= h2c_data;
      if (c2h_push) c2h_mem[c2h_wptr] <= avs_writedata;
   end

   // Host-to-CPU pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         h2c_wptr  <= '0;
         h2c_rptr  <= '0;
         h2c_count <= '0;
      end else begin
         if (h2c_push) h2c_wptr <= h2c_wptr + AW'(1);
         if (h2c_pop)  h2c_rptr <= h2c_rptr + AW'(1);
         case ({h2c_push, h2c_pop})
            2'b10:   h2c_count <= h2c_count + CNT_W'(1);
            2'b01:   h2c_count <= h2c_count - CNT_W'(1);
            default: h2c_count <= h2c_count;
         endcase
      end
   end

   // CPU-to-host pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         c2h_wptr  <= '0;
         c2h_rptr  <= '0;
         c2h_count <= '0;
      end else begin
         if (c2h_push) c2h_wptr <= c2h_wptr + AW'(1);
         if (c2h_pop)  c2h_rptr <= c2h_rptr + AW'(1);
         case ({c2h_push, c2h_pop})
            2'b10:   c2h_count <= c2h_count + CNT_W'(1);
            2'b01:   c2h_count <= c2h_count - CNT_W'(1);
            default: c2h_count <= c2h_count;
         endcase
      end
   end

   // Sticky error flags. A new error event overrides a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         h2c_underflow <= 1'b0;
         c2h_overflow  <= 1'b0;
      end else begin
         if (h2c_pop_req & h2c_empty)            h2c_underflow <= 1'b1;
         else if (ctrl_wr & avs_writedata[1])    h2c_underflow <= 1'b0;
         if (c2h_push_req & c2h_full)            c2h_overflow  <= 1'b1;
         else if (ctrl_wr & avs_writedata[1])    c2h_overflow  <= 1'b0;
      end
   end

   // Scratch register with per-byte write enables.
   always_ff @(posedge clk) begin
      if (rst) begin
         scratch <= '0;
      end else if (scratch_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (avs_byteenable[b]) scratch[8*b +: 8] <= avs_writedata[8*b +: 8];
         end
      end
   end

   // Registered read response and doorbell, one cycle after the accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         avs_readdatavalid <= 1'b0;
         avs_readdata      <= '0;
         done_pulse        <= 1'b0;
      end else begin
         avs_readdatavalid <= rd_acc;
         avs_readdata      <= rd_acc ? rd_mux : 32'h0;
         done_pulse        <= ctrl_wr & avs_writedata[0];
      end
   end

endmodule
